pixel_sink: RTL and testbench

- Receiving end of the pixel-plot interface (x, y, colour, plot) that drawing FSMs drive.
- Accepts plot requests from one drawing unit through a valid/ready handshake and buffers them in a small FIFO.
- Converts each (x, y) into a linear 160x120 framebuffer address and issues handshaked writes to the framebuffer RAM port.
- Also performs a full-screen clear sweep on request, so shapes can be wiped between game rounds.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/pixel_sink_if.sv | 35 +++
 rtl/pixel_fifo.sv | 52 +++++
 rtl/pixel_sink.sv | 128 ++++++++++++
 tb/tb_pixel_sink.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and address helper for the 160x120 pixel
// path; address maths stays here so every producer agrees on the layout.
package vga_pkg;

  localparam int unsigned H_RES    = 160;
  localparam int unsigned V_RES    = 120;
  localparam int unsigned FB_WORDS = H_RES * V_RES;
  localparam int          ADDR_W   = 15;
  localparam int          COLOUR_W = 3;
  localparam int          X_W      = 8;
  localparam int          Y_W      = 7;

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } fb_word_t;

  // y*160 + x as two shifts and an add; the largest result (19199) fits 15 bits.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// Plot request, clear control, framebuffer write port and status flags of the
// pixel sink. The drawing side is the master, the pixel sink is the slave.
interface pixel_sink_if;
  import vga_pkg::*;

  logic                plot;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot_ready;

  logic                clear_req;
  logic [COLOUR_W-1:0] clear_colour;
  logic                clear_done;

  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOUR_W-1:0] fb_data;
  logic                fb_we;
  logic                fb_ready;

  logic                busy;
  logic                overflow;
  logic                oob;

  modport master (
    output plot, x, y, colour, clear_req, clear_colour, fb_ready,
    input  plot_ready, clear_done, fb_addr, fb_data, fb_we, busy, overflow, oob
  );

  modport slave (
    input  plot, x, y, colour, clear_req, clear_colour, fb_ready,
    output plot_ready, clear_done, fb_addr, fb_data, fb_we, busy, overflow, oob
  );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a combinational head output; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    dout     = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_sink.sv
// Receives plot requests, buffers them, and issues handshaked framebuffer
// writes; also sweeps the whole screen with one colour on a clear request.
module pixel_sink #(
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned H_RES      = vga_pkg::H_RES,
  parameter int unsigned V_RES      = vga_pkg::V_RES
) (
  input logic         clk,
  input logic         reset_n,
  pixel_sink_if.slave pif
);
  import vga_pkg::*;

  state_e              state_q, state_d;
  logic                clear_pending_q, clear_pending_d;
  logic [COLOUR_W-1:0] clear_colour_q, clear_colour_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                clear_done_q, clear_done_d;
  logic                overflow_q, overflow_d;
  logic                oob_q, oob_d;
  logic                out_we_q, out_we_d;
  fb_word_t            out_q, out_d;

  logic                plot_ready, accept, in_range, load;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  fb_word_t            fifo_din, fifo_dout;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fb_word_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Input side, output stage and sticky flags.
  always_comb begin
    plot_ready      = !fifo_full && (state_q == IDLE) && !clear_pending_q;
    accept          = pif.plot && plot_ready;
    in_range        = (32'(pif.x) < H_RES) && (32'(pif.y) < V_RES);
    fifo_push       = accept && in_range;
    fifo_din.addr   = pixel_addr(pif.x, pif.y);
    fifo_din.colour = pif.colour;

    // The stage refills when empty or when its current word is taken this edge.
    load     = (state_q == IDLE) && (!out_we_q || pif.fb_ready);
    fifo_pop = load && !fifo_empty;
    out_we_d = load ? !fifo_empty : out_we_q;
    out_d    = fifo_pop ? fifo_dout : out_q;

    overflow_d = overflow_q | (pif.plot && !plot_ready);
    oob_d      = oob_q | (accept && !in_range);
  end

  // Clear sequencing: pending latch plus the IDLE/CLEAR sweep machine.
  always_comb begin
    state_d         = state_q;
    sweep_d         = sweep_q;
    clear_done_d    = 1'b0;
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;

    if (pif.clear_req && !clear_pending_q && (state_q == IDLE)) begin
      clear_pending_d = 1'b1;
      clear_colour_d  = pif.clear_colour;
    end

    case (state_q)
      IDLE: begin
        // Waiting for an empty pipe is what orders earlier plots before the wipe.
        if (clear_pending_q && fifo_empty && !out_we_q) state_d = CLEAR;
      end
      CLEAR: begin
        if (pif.fb_ready) begin
          if (sweep_q == FB_LAST) begin
            state_d         = IDLE;
            sweep_d         = '0;
            clear_done_d    = 1'b1;
            clear_pending_d = 1'b0;
          end else begin
            sweep_d = sweep_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      sweep_q         <= '0;
      clear_done_q    <= 1'b0;
      overflow_q      <= 1'b0;
      oob_q           <= 1'b0;
      out_we_q        <= 1'b0;
      out_q           <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      sweep_q         <= sweep_d;
      clear_done_q    <= clear_done_d;
      overflow_q      <= overflow_d;
      oob_q           <= oob_d;
      out_we_q        <= out_we_d;
      out_q           <= out_d;
    end
  end

  assign pif.plot_ready = plot_ready;
  assign pif.fb_we      = (state_q == CLEAR) || out_we_q;
  assign pif.fb_addr    = (state_q == CLEAR) ? sweep_q : out_q.addr;
  assign pif.fb_data    = (state_q == CLEAR) ? clear_colour_q : out_q.colour;
  assign pif.clear_done = clear_done_q;
  assign pif.busy       = !fifo_empty || out_we_q || clear_pending_q || (state_q == CLEAR);
  assign pif.overflow   = overflow_q;
  assign pif.oob        = oob_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: expected write streams come from plain
// y*160+x arithmetic and queues, compared against writes seen on the RAM port.
module tb_pixel_sink;

  localparam int FIFO_DEPTH = 4;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int WORDS      = SCREEN_W * SCREEN_H;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  logic [17:0] wr_q[$];
  logic [17:0] exp_q[$];

  pixel_sink_if pif ();

  pixel_sink #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .H_RES      (SCREEN_W),
    .V_RES      (SCREEN_H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pif     (pif)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge, so at the falling edge they hold
  // the values the next rising edge will act on.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pif.fb_we && pif.fb_ready) wr_q.push_back({pif.fb_addr, pif.fb_data});
      if (pif.clear_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] pix(input int xi, input int yi, input logic [2:0] c);
    int a;
    a = yi * SCREEN_W + xi;
    return {15'(a), c};
  endfunction

  function automatic int stream_mismatches();
    int mm;
    mm = 0;
    if (wr_q.size() != exp_q.size()) mm++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) mm++;
    return mm;
  endfunction

  task automatic test_reset();
    pif.plot = 0; pif.x = '0; pif.y = '0; pif.colour = '0;
    pif.clear_req = 0; pif.clear_colour = '0; pif.fb_ready = 1;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pif.fb_we, pif.busy, pif.overflow, pif.oob, pif.clear_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got we/busy/ovf/oob/done=%b want 00000",
               {pif.fb_we, pif.busy, pif.overflow, pif.oob, pif.clear_done});
    end
    checks++;
    if ({pif.fb_addr, pif.fb_data} !== 18'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%0d data=%0d want 0/0", pif.fb_addr, pif.fb_data);
    end
    reset_n = 1;
    tick();
    checks++;
    if (pif.plot_ready !== 1'b1 || pif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1/0", pif.plot_ready, pif.busy);
    end
  endtask

  task automatic test_basic();
    wr_q.delete(); exp_q.delete();
    pif.fb_ready = 1;
    pif.x = 8'd3; pif.y = 7'd2; pif.colour = 3'b100; pif.plot = 1;
    checks++;
    if (pif.plot_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b want 1", pif.plot_ready);
    end
    tick();
    pif.plot = 0;
    checks++;
    if (pif.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: fb_we=%b one edge after accept, want 0", pif.fb_we);
    end
    tick();
    checks++;
    if ({pif.fb_we, pif.fb_addr, pif.fb_data} !== {1'b1, pix(3, 2, 3'b100)}) begin
      errors++;
      $display("FAIL basic_write: got we=%b addr=%0d data=%0d want 1/323/4",
               pif.fb_we, pif.fb_addr, pif.fb_data);
    end
    tick();
    checks++;
    if (pif.fb_we !== 1'b0 || pif.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got we=%b busy=%b want 0/0", pif.fb_we, pif.busy);
    end
    exp_q.push_back(pix(3, 2, 3'b100));
    checks++;
    if (stream_mismatches() !== 0) begin
      errors++;
      $display("FAIL basic_stream: got %0d writes want 1 write of addr 323", wr_q.size());
    end
  endtask

  task automatic test_corner_oob();
    wr_q.delete(); exp_q.delete();
    pif.fb_ready = 1;
    pif.x = 8'd159; pif.y = 7'd119; pif.colour = 3'd7; pif.plot = 1;
    tick();
    checks++;
    if (pif.oob !== 1'b0) begin
      errors++;
      $display("FAIL corner_oob_early: oob=%b after in-range pixel, want 0", pif.oob);
    end
    pif.x = 8'd160; pif.y = 7'd0; pif.colour = 3'd5;
    tick();
    pif.x = 8'd0; pif.y = 7'd120; pif.colour = 3'd2;
    tick();
    pif.plot = 0;
    repeat (6) tick();
    exp_q.push_back(pix(159, 119, 3'd7));
    checks++;
    if (stream_mismatches() !== 0) begin
      errors++;
      $display("FAIL corner_stream: got %0d writes (first=%h) want 1 write %h",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 18'h0, exp_q[0]);
    end
    checks++;
    if (wr_q.size() < 1 || wr_q[0][17:3] !== 15'd19199) begin
      errors++;
      $display("FAIL corner_addr: first write addr wrong or missing, want 19199");
    end
    checks++;
    if (pif.oob !== 1'b1 || pif.overflow !== 1'b0) begin
      errors++;
      $display("FAIL corner_flags: got oob=%b overflow=%b want 1/0", pif.oob, pif.overflow);
    end
  endtask

  task automatic test_backpressure();
    int xi, yi;
    logic [2:0] ci;
    logic exp_ready;
    logic [17:0] head;
    wr_q.delete(); exp_q.delete();
    pif.fb_ready = 0;
    for (int i = 0; i < 6; i++) begin
      xi = $urandom_range(0, SCREEN_W - 1);
      yi = $urandom_range(0, SCREEN_H - 1);
      ci = 3'($urandom_range(0, 7));
      pif.x = 8'(xi); pif.y = 7'(yi); pif.colour = ci; pif.plot = 1;
      // FIFO entries plus the single output register bound what can be held.
      exp_ready = (i < FIFO_DEPTH + 1);
      checks++;
      if (pif.plot_ready !== exp_ready) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b want %b", i, pif.plot_ready, exp_ready);
      end
      if (exp_ready) exp_q.push_back(pix(xi, yi, ci));
      tick();
    end
    pif.plot = 0;
    checks++;
    if (pif.overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: got %b want 1", pif.overflow);
    end
    repeat (4) tick();
    head = exp_q[0];
    checks++;
    if ({pif.fb_we, pif.fb_addr, pif.fb_data} !== {1'b1, head} || pif.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got we=%b word=%h busy=%b want 1/%h/1",
               pif.fb_we, {pif.fb_addr, pif.fb_data}, pif.busy, head);
    end
    pif.fb_ready = 1;
    repeat (10) tick();
    checks++;
    if (stream_mismatches() !== 0 || wr_q.size() != FIFO_DEPTH + 1) begin
      errors++;
      $display("FAIL bp_stream: got %0d writes (%0d differ) want %0d in order",
               wr_q.size(), stream_mismatches(), FIFO_DEPTH + 1);
    end
  endtask

  task automatic test_back_to_back();
    int xi, yi, waited;
    logic [2:0] ci;
    wr_q.delete(); exp_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      pif.fb_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0 && pif.plot_ready) begin
        xi = $urandom_range(0, 175);
        yi = $urandom_range(0, 127);
        ci = 3'($urandom_range(0, 7));
        pif.x = 8'(xi); pif.y = 7'(yi); pif.colour = ci; pif.plot = 1;
        if (xi < SCREEN_W && yi < SCREEN_H) exp_q.push_back(pix(xi, yi, ci));
      end else begin
        pif.plot = 0;
      end
      tick();
    end
    pif.plot = 0;
    pif.fb_ready = 1;
    waited = 0;
    while (pif.busy !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (pif.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b after 20 cycles, want 0", pif.busy);
    end
    checks++;
    if (stream_mismatches() !== 0) begin
      errors++;
      $display("FAIL b2b_stream: got %0d writes want %0d, %0d differ",
               wr_q.size(), exp_q.size(), stream_mismatches());
    end
  endtask

  task automatic test_clear_with_queue();
    int xi, yi, cyc, ready_viol;
    logic [2:0] ci;
    wr_q.delete(); exp_q.delete();
    done_cnt = 0;
    pif.fb_ready = 0;
    for (int i = 0; i < 2; i++) begin
      xi = $urandom_range(0, SCREEN_W - 1);
      yi = $urandom_range(0, SCREEN_H - 1);
      ci = 3'($urandom_range(0, 7));
      pif.x = 8'(xi); pif.y = 7'(yi); pif.colour = ci; pif.plot = 1;
      exp_q.push_back(pix(xi, yi, ci));
      tick();
    end
    pif.plot = 0;
    pif.clear_colour = 3'b001; pif.clear_req = 1;
    tick();
    pif.clear_req = 0; pif.clear_colour = 3'b110;
    pif.fb_ready = 1;
    cyc = 0; ready_viol = 0;
    while (pif.clear_done !== 1'b1 && cyc < WORDS + 900) begin
      if (pif.plot_ready !== 1'b0) ready_viol++;
      tick();
      cyc++;
    end
    checks++;
    if (pif.clear_done !== 1'b1) begin
      errors++;
      $display("FAIL clr_timeout: clear_done=%b after %0d cycles, want 1", pif.clear_done, cyc);
    end
    checks++;
    if (ready_viol !== 0) begin
      errors++;
      $display("FAIL clr_ready: plot_ready high on %0d cycles, want 0", ready_viol);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL clr_done_count: got %0d pulses want 1", done_cnt);
    end
    for (int i = 0; i < WORDS; i++) exp_q.push_back({15'(i), 3'b001});
    checks++;
    if (stream_mismatches() !== 0) begin
      errors++;
      $display("FAIL clr_stream: got %0d writes want %0d, %0d differ",
               wr_q.size(), exp_q.size(), stream_mismatches());
    end
    checks++;
    if (pif.busy !== 1'b0 || pif.plot_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_after: got busy=%b ready=%b want 0/1", pif.busy, pif.plot_ready);
    end
  endtask

  task automatic test_random_ready_sweep();
    int cyc;
    wr_q.delete(); exp_q.delete();
    done_cnt = 0;
    pif.fb_ready = 1;
    pif.clear_colour = 3'b110; pif.clear_req = 1;
    tick();
    pif.clear_req = 0;
    cyc = 0;
    while (pif.clear_done !== 1'b1 && cyc < 60000) begin
      pif.fb_ready = ($urandom_range(0, 3) != 0);
      // A second request mid-sweep must be ignored entirely.
      if (cyc == 500) begin
        pif.clear_req = 1; pif.clear_colour = 3'b010;
      end else begin
        pif.clear_req = 0;
      end
      tick();
      cyc++;
    end
    pif.clear_req = 0;
    pif.fb_ready = 1;
    repeat (4) tick();
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL rsweep_done: got %0d pulses after %0d cycles want 1", done_cnt, cyc);
    end
    for (int i = 0; i < WORDS; i++) exp_q.push_back({15'(i), 3'b110});
    checks++;
    if (stream_mismatches() !== 0) begin
      errors++;
      $display("FAIL rsweep_stream: got %0d writes want %0d, %0d differ",
               wr_q.size(), exp_q.size(), stream_mismatches());
    end
    checks++;
    if (pif.busy !== 1'b0 || pif.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL rsweep_idle: got busy=%b we=%b want 0/0", pif.busy, pif.fb_we);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    wr_q.delete();
    pif.fb_ready = 1;
    pif.clear_colour = 3'b111; pif.clear_req = 1;
    tick();
    pif.clear_req = 0;
    cyc = 0;
    while (wr_q.size() < 5000 && cyc < 6000) begin
      tick();
      cyc++;
    end
    checks++;
    if (pif.fb_we !== 1'b1 || wr_q.size() < 5000) begin
      errors++;
      $display("FAIL rst_mid_pre: got we=%b writes=%0d want 1/>=5000", pif.fb_we, wr_q.size());
    end
    reset_n = 0;
    #1;
    checks++;
    if ({pif.fb_we, pif.busy, pif.overflow, pif.oob, pif.clear_done} !== 5'b0 ||
        {pif.fb_addr, pif.fb_data} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got we/busy/ovf/oob/done=%b addr=%0d data=%0d want all 0",
               {pif.fb_we, pif.busy, pif.overflow, pif.oob, pif.clear_done},
               pif.fb_addr, pif.fb_data);
    end
    repeat (2) tick();
    reset_n = 1;
    tick();
    checks++;
    if (pif.plot_ready !== 1'b1 || pif.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: got ready=%b busy=%b want 1/0", pif.plot_ready, pif.busy);
    end
    wr_q.delete();
    repeat (20) tick();
    checks++;
    if (wr_q.size() !== 0 || pif.fb_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d writes we=%b want 0/0", wr_q.size(), pif.fb_we);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner_oob();
    test_backpressure();
    test_back_to_back();
    test_clear_with_queue();
    test_random_ready_sweep();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
